// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin mux select sequencer.
// Holds the arbiter state enum, the select encodings and a clog2 helper.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Bits needed to index v distinct values (v >= 2 gives at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_reg_slice.sv
// One-entry valid/ready output register capturing the mux output.
// Ports: clk, rst, load/din (capture), y_ready/y_valid/y_data (consumer), space.
module out_reg_slice #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             y_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             space
);

  // A full register can still accept when the consumer drains it this cycle.
  assign space = !y_valid || y_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (load) begin
      y_valid <= 1'b1;
      y_data  <= din;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_mux_sequencer.sv
// Round-robin arbiter driving a registered 2:1 mux select, bursts up to
// MAX_BURST per grant. Ports: clk, rst, a/b valid/ready, sel, mux_y, y_*.
module rr_mux_sequencer
  import mux_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y_data
);

  localparam int CW = clog2(MAX_BURST + 1);

  state_t          state_q;
  state_t          state_d;
  logic            sel_q;
  logic            sel_d;
  logic            last_q;
  logic            last_d;
  logic [CW-1:0]   burst_cnt;
  logic [CW-1:0]   burst_cnt_d;
  logic [CW-1:0]   burst_inc;
  logic            burst_done;
  logic            space;
  logic            a_xfer;
  logic            b_xfer;

  assign a_ready = (state_q == GRANT_A) && space;
  assign b_ready = (state_q == GRANT_B) && space;
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;
  assign sel     = sel_q;

  assign burst_inc  = burst_cnt + CW'(1);
  assign burst_done = (burst_inc == CW'(MAX_BURST));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (a_valid && b_valid):
            state_d = (last_q == SEL_B) ? GRANT_A : GRANT_B;
          (a_valid && !b_valid):
            state_d = GRANT_A;
          (!a_valid && b_valid):
            state_d = GRANT_B;
          default: ;
        endcase
      end
      GRANT_A: begin
        if (a_xfer && !burst_done) begin
          burst_cnt_d = burst_inc;
        end else if (a_xfer || !a_valid) begin
          burst_cnt_d = '0;
          last_d      = SEL_A;
          state_d     = b_valid ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (b_xfer && !burst_done) begin
          burst_cnt_d = burst_inc;
        end else if (b_xfer || !b_valid) begin
          burst_cnt_d = '0;
          last_d      = SEL_B;
          state_d     = a_valid ? GRANT_A : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
    // sel follows the upcoming grant and keeps its value through IDLE.
    if (state_d == GRANT_A) sel_d = SEL_A;
    else if (state_d == GRANT_B) sel_d = SEL_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= SEL_A;
      last_q    <= SEL_B;
      burst_cnt <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      burst_cnt <= burst_cnt_d;
    end
  end

  out_reg_slice #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (a_xfer || b_xfer),
    .din    (mux_y),
    .y_ready(y_ready),
    .y_valid(y_valid),
    .y_data (y_data),
    .space  (space)
  );

endmodule

// File: tb/tb_rr_mux_sequencer.sv
// Bench for rr_mux_sequencer: two instances (MAX_BURST 4 and 2) with
// queue-driven sources, directed scenarios and a randomized run.
module tb_rr_mux_sequencer;

  logic       clk;
  logic       rst;
  logic       a_valid [2];
  logic       b_valid [2];
  logic       y_ready [2];
  logic [7:0] a_data [2];
  logic [7:0] b_data [2];
  logic [7:0] mux_y [2];
  logic [7:0] y_data_o [2];
  logic       a_ready_o [2];
  logic       b_ready_o [2];
  logic       sel_o [2];
  logic       y_valid_o [2];

  int npass;
  int nchk;

  logic [7:0] aq0[$];
  logic [7:0] bq0[$];
  logic [7:0] aq1[$];
  logic [7:0] bq1[$];

  // Reference model: owner 0 = none, 1 = A, 2 = B.
  int         m_own [2];
  int         m_run [2];
  int         m_prev [2];
  int         mb [2];
  logic       m_sel [2];
  logic       m_yv [2];
  logic [7:0] m_yd [2];
  bit         m_xa [2];
  bit         m_xb [2];

  // The integration-level mux this block drives.
  assign mux_y[0] = sel_o[0] ? b_data[0] : a_data[0];
  assign mux_y[1] = sel_o[1] ? b_data[1] : a_data[1];

  rr_mux_sequencer #(.WIDTH(8), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[0]), .a_ready(a_ready_o[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready_o[0]),
    .sel(sel_o[0]), .mux_y(mux_y[0]),
    .y_valid(y_valid_o[0]), .y_ready(y_ready[0]),
    .y_data(y_data_o[0])
  );

  rr_mux_sequencer #(.WIDTH(8), .MAX_BURST(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid[1]), .a_ready(a_ready_o[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready_o[1]),
    .sel(sel_o[1]), .mux_y(mux_y[1]),
    .y_valid(y_valid_o[1]), .y_ready(y_ready[1]),
    .y_data(y_data_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input int k);
    bit room;
    bit xa;
    bit xb;
    bit mine;
    bit other;
    int me;
    logic [7:0] din;
    if (rst) begin
      m_own[k] = 0; m_run[k] = 0; m_prev[k] = 2;
      m_sel[k] = 1'b0; m_yv[k] = 1'b0; m_yd[k] = 8'h00;
      m_xa[k] = 1'b0; m_xb[k] = 1'b0;
      return;
    end
    room = !m_yv[k] || y_ready[k];
    xa = (m_own[k] == 1) && room && a_valid[k];
    xb = (m_own[k] == 2) && room && b_valid[k];
    din = m_sel[k] ? b_data[k] : a_data[k];
    m_xa[k] = xa;
    m_xb[k] = xb;
    if (xa || xb) begin
      m_yv[k] = 1'b1;
      m_yd[k] = din;
    end else if (m_yv[k] && y_ready[k]) begin
      m_yv[k] = 1'b0;
    end
    if (m_own[k] == 0) begin
      if (a_valid[k] && b_valid[k]) m_own[k] = (m_prev[k] == 1) ? 2 : 1;
      else if (a_valid[k]) m_own[k] = 1;
      else if (b_valid[k]) m_own[k] = 2;
    end else begin
      me = m_own[k];
      mine = (me == 1) ? a_valid[k] : b_valid[k];
      other = (me == 1) ? b_valid[k] : a_valid[k];
      if (xa || xb) m_run[k] = m_run[k] + 1;
      if ((xa || xb) ? (m_run[k] == mb[k]) : !mine) begin
        m_run[k] = 0;
        m_prev[k] = me;
        m_own[k] = other ? 3 - me : 0;
      end
    end
    if (m_own[k] == 1) m_sel[k] = 1'b0;
    else if (m_own[k] == 2) m_sel[k] = 1'b1;
  endtask

  // Retire accepted items and present queue heads as source inputs.
  task automatic refresh();
    logic [7:0] t;
    if (m_xa[0]) t = aq0.pop_front();
    if (m_xb[0]) t = bq0.pop_front();
    if (m_xa[1]) t = aq1.pop_front();
    if (m_xb[1]) t = bq1.pop_front();
    m_xa[0] = 0; m_xb[0] = 0; m_xa[1] = 0; m_xb[1] = 0;
    a_valid[0] = (aq0.size() != 0);
    b_valid[0] = (bq0.size() != 0);
    a_valid[1] = (aq1.size() != 0);
    b_valid[1] = (bq1.size() != 0);
    a_data[0] = (aq0.size() != 0) ? aq0[0] : 8'h00;
    b_data[0] = (bq0.size() != 0) ? bq0[0] : 8'h00;
    a_data[1] = (aq1.size() != 0) ? aq1[0] : 8'h00;
    b_data[1] = (bq1.size() != 0) ? bq1[0] : 8'h00;
    #1;
  endtask

  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    aq0.delete(); bq0.delete(); aq1.delete(); bq1.delete();
    y_ready[0] = 1'b1;
    y_ready[1] = 1'b1;
    refresh();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    aq0.push_back(8'hA0); aq0.push_back(8'hA1);
    bq0.push_back(8'hB0);
    refresh();
    step();
    step();
    nchk++; if (sel_o[0] !== 1'b0) begin
      $display("FAIL reset_sel got %b want 0", sel_o[0]); end else npass++;
    nchk++; if (y_valid_o[0] !== 1'b0) begin
      $display("FAIL reset_yvalid got %b want 0", y_valid_o[0]); end else npass++;
    nchk++; if (y_data_o[0] !== 8'h00) begin
      $display("FAIL reset_ydata got %h want 00", y_data_o[0]); end else npass++;
    nchk++; if (a_ready_o[0] !== 1'b0 || b_ready_o[0] !== 1'b0) begin
      $display("FAIL reset_ready got %b%b want 00", a_ready_o[0], b_ready_o[0]);
    end else npass++;
    rst = 1'b0;
    #1;
    step();
    nchk++; if (a_ready_o[0] !== 1'b1 || b_ready_o[0] !== 1'b0) begin
      $display("FAIL reset_first_grant got %b%b want 10",
               a_ready_o[0], b_ready_o[0]);
    end else npass++;
    step();
    nchk++; if (y_valid_o[0] !== 1'b1 || y_data_o[0] !== 8'hA0) begin
      $display("FAIL reset_first_data got %b/%h want 1/a0",
               y_valid_o[0], y_data_o[0]);
    end else npass++;
  endtask

  task automatic test_stream();
    bit         ev [7];
    logic [7:0] ed [7];
    ev = '{0, 1, 1, 1, 1, 0, 1};
    ed = '{8'h0, 8'h1, 8'h0, 8'h1, 8'h1, 8'h0, 8'h0};
    do_reset();
    aq0.push_back(8'h1); aq0.push_back(8'h0); aq0.push_back(8'h1);
    aq0.push_back(8'h1); aq0.push_back(8'h0);
    refresh();
    for (int i = 0; i < 7; i++) begin
      step();
      nchk++; if (y_valid_o[0] !== ev[i]) begin
        $display("FAIL stream_yvalid[%0d] got %b want %b", i, y_valid_o[0], ev[i]);
      end else npass++;
      if (ev[i]) begin
        nchk++; if (y_data_o[0] !== ed[i]) begin
          $display("FAIL stream_ydata[%0d] got %h want %h", i, y_data_o[0], ed[i]);
        end else npass++;
      end
    end
  endtask

  task automatic test_contention();
    bit         es [6];
    logic [7:0] eo [6];
    es = '{0, 0, 1, 1, 0, 0};
    eo = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      aq1.push_back(8'hA0 + 8'(i));
      bq1.push_back(8'hB0 + 8'(i));
    end
    refresh();
    for (int i = 0; i < 7; i++) begin
      step();
      if (i < 6) begin
        nchk++; if (sel_o[1] !== es[i]) begin
          $display("FAIL contention_sel[%0d] got %b want %b", i, sel_o[1], es[i]);
        end else npass++;
      end
      if (i >= 1) begin
        nchk++; if (y_valid_o[1] !== 1'b1 || y_data_o[1] !== eo[i-1]) begin
          $display("FAIL contention_order[%0d] got %b/%h want 1/%h",
                   i, y_valid_o[1], y_data_o[1], eo[i-1]);
        end else npass++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    aq0.push_back(8'h11); aq0.push_back(8'h22);
    aq0.push_back(8'h33); aq0.push_back(8'h44);
    refresh();
    step();
    step();
    y_ready[0] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nchk++; if (a_ready_o[0] !== 1'b0 || y_valid_o[0] !== 1'b1 ||
                  y_data_o[0] !== 8'h11 || sel_o[0] !== 1'b0) begin
        $display("FAIL backpressure_hold[%0d] got ar=%b yv=%b yd=%h sel=%b want 0/1/11/0",
                 i, a_ready_o[0], y_valid_o[0], y_data_o[0], sel_o[0]);
      end else npass++;
      step();
    end
    y_ready[0] = 1'b1;
    #1;
    nchk++; if (a_ready_o[0] !== 1'b1) begin
      $display("FAIL backpressure_release got %b want 1", a_ready_o[0]);
    end else npass++;
    step();
    nchk++; if (y_valid_o[0] !== 1'b1 || y_data_o[0] !== 8'h22) begin
      $display("FAIL backpressure_next got %b/%h want 1/22",
               y_valid_o[0], y_data_o[0]);
    end else npass++;
  endtask

  task automatic test_early_release();
    do_reset();
    aq0.push_back(8'h5A);
    bq0.push_back(8'hB1); bq0.push_back(8'hB2);
    refresh();
    step();
    step();
    nchk++; if (u_dut0.burst_cnt !== 3'd1 || sel_o[0] !== 1'b0) begin
      $display("FAIL early_pre got cnt=%0d sel=%b want 1/0",
               u_dut0.burst_cnt, sel_o[0]);
    end else npass++;
    step();
    nchk++; if (sel_o[0] !== 1'b1 || b_ready_o[0] !== 1'b1 ||
                u_dut0.burst_cnt !== 3'd0) begin
      $display("FAIL early_release got sel=%b br=%b cnt=%0d want 1/1/0",
               sel_o[0], b_ready_o[0], u_dut0.burst_cnt);
    end else npass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bq0.push_back(8'hC1); bq0.push_back(8'hC2); bq0.push_back(8'hC3);
    refresh();
    step();
    step();
    nchk++; if (sel_o[0] !== 1'b1 || y_valid_o[0] !== 1'b1) begin
      $display("FAIL midreset_pre got sel=%b yv=%b want 1/1", sel_o[0], y_valid_o[0]);
    end else npass++;
    rst = 1'b1;
    aq0.push_back(8'hA7);
    refresh();
    step();
    rst = 1'b0;
    #1;
    nchk++; if (y_valid_o[0] !== 1'b0 || sel_o[0] !== 1'b0 ||
                a_ready_o[0] !== 1'b0 || b_ready_o[0] !== 1'b0) begin
      $display("FAIL midreset_clear got yv=%b sel=%b ar=%b br=%b want 0/0/0/0",
               y_valid_o[0], sel_o[0], a_ready_o[0], b_ready_o[0]);
    end else npass++;
    step();
    nchk++; if (sel_o[0] !== 1'b0 || a_ready_o[0] !== 1'b1) begin
      $display("FAIL midreset_tie got sel=%b ar=%b want 0/1", sel_o[0], a_ready_o[0]);
    end else npass++;
  endtask

  task automatic test_random();
    logic [7:0] v;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (aq0.size() < 4 && $urandom_range(0, 2) == 0) begin
        v = 8'($urandom); aq0.push_back(v); end
      if (bq0.size() < 4 && $urandom_range(0, 2) == 0) begin
        v = 8'($urandom); bq0.push_back(v); end
      if (aq1.size() < 4 && $urandom_range(0, 1) == 0) begin
        v = 8'($urandom); aq1.push_back(v); end
      if (bq1.size() < 4 && $urandom_range(0, 1) == 0) begin
        v = 8'($urandom); bq1.push_back(v); end
      y_ready[0] = ($urandom_range(0, 3) != 0);
      y_ready[1] = ($urandom_range(0, 3) != 0);
      refresh();
      for (int k = 0; k < 2; k++) begin
        nchk++; if (sel_o[k] !== m_sel[k]) begin
          $display("FAIL rand_sel[%0d] c=%0d got %b want %b", k, c, sel_o[k], m_sel[k]);
        end else npass++;
        nchk++; if (a_ready_o[k] !== (m_own[k] == 1 && (!m_yv[k] || y_ready[k]))) begin
          $display("FAIL rand_a_ready[%0d] c=%0d got %b", k, c, a_ready_o[k]);
        end else npass++;
        nchk++; if (b_ready_o[k] !== (m_own[k] == 2 && (!m_yv[k] || y_ready[k]))) begin
          $display("FAIL rand_b_ready[%0d] c=%0d got %b", k, c, b_ready_o[k]);
        end else npass++;
        nchk++; if (y_valid_o[k] !== m_yv[k]) begin
          $display("FAIL rand_yvalid[%0d] c=%0d got %b want %b",
                   k, c, y_valid_o[k], m_yv[k]);
        end else npass++;
        nchk++; if (y_data_o[k] !== m_yd[k]) begin
          $display("FAIL rand_ydata[%0d] c=%0d got %h want %h",
                   k, c, y_data_o[k], m_yd[k]);
        end else npass++;
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    npass = 0;
    nchk  = 0;
    mb[0] = 4;
    mb[1] = 2;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_xa[k] = 0; m_xb[k] = 0;
      m_own[k] = 0; m_run[k] = 0; m_prev[k] = 2;
      m_sel[k] = 1'b0; m_yv[k] = 1'b0; m_yd[k] = 8'h00;
      y_ready[k] = 1'b1;
    end
    refresh();
    test_reset();
    test_stream();
    test_contention();
    test_backpressure();
    test_early_release();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
